// File: rtl/led_tile_row_scanner_if.sv
// rtl/led_tile_row_scanner_if.sv - frame-buffer read port and LED panel pins of the row scanner
interface led_tile_row_scanner_if #(
  parameter int COLS = 32,
  parameter int ROWS = 16
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [RW+CW:0] fb_addr;
  logic [2:0]     fb_rddata;
  logic [2:0]     led_rgb;
  logic           led_sclk;
  logic           led_latch;
  logic           led_oe_n;
  logic [RW-1:0]  led_row;

  modport master (
    output fb_addr,
    input  fb_rddata,
    output led_rgb,
    output led_sclk,
    output led_latch,
    output led_oe_n,
    output led_row
  );

  modport slave (
    input  fb_addr,
    output fb_rddata,
    input  led_rgb,
    input  led_sclk,
    input  led_latch,
    input  led_oe_n,
    input  led_row
  );
endinterface

// File: rtl/led_tile_row_scanner.sv
// rtl/led_tile_row_scanner.sv - scans a double-buffered LED tile frame buffer out to the panel
module led_tile_row_scanner #(
  parameter int COLS    = 32,
  parameter int ROWS    = 16,
  parameter int ON_UNIT = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   ctrl,
  led_tile_row_scanner_if.master       bus,
  output logic                         active_buf,
  output logic                         frame_done
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int OW = $clog2(16 * ON_UNIT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CLK, S_LATCH, S_SHOW
  } state_t;

  state_t state, next_state;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [OW-1:0] on_cnt;
  logic [3:0]    bright;
  logic [2:0]    rgb_q;
  logic [RW-1:0] row_q;
  logic [31:0]   on_thresh;
  logic          col_last, row_last, show_last, on_phase;

  assign col_last  = (col == CW'(COLS - 1));
  assign row_last  = (row == RW'(ROWS - 1));
  assign show_last = (on_cnt == OW'(16 * ON_UNIT - 1));
  assign on_thresh = 32'(bright) * 32'(ON_UNIT);
  assign on_phase  = (32'(on_cnt) < on_thresh);

  assign bus.fb_addr = {active_buf, row, col};
  assign bus.led_rgb = rgb_q;
  assign bus.led_row = row_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (ctrl[1]) next_state = S_ADDR;
      S_ADDR:  next_state = S_DATA;
      S_DATA:  next_state = S_CLK;
      S_CLK:   next_state = col_last ? S_LATCH : S_ADDR;
      S_LATCH: next_state = S_SHOW;
      S_SHOW:  if (show_last) next_state = ctrl[1] ? S_ADDR : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.led_sclk  = 1'b0;
    bus.led_latch = 1'b0;
    bus.led_oe_n  = 1'b1;
    frame_done    = 1'b0;
    case (state)
      S_CLK:   bus.led_sclk  = 1'b1;
      S_LATCH: bus.led_latch = 1'b1;
      S_SHOW: begin
        bus.led_oe_n = !on_phase;
        frame_done   = show_last && row_last;
      end
      default: ;
    endcase
  end

  // Counters and data registers; the front buffer only changes at a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      on_cnt     <= '0;
      bright     <= '0;
      rgb_q      <= '0;
      row_q      <= '0;
      active_buf <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          col <= '0;
          if (ctrl[1]) begin
            active_buf <= ctrl[0];
            row        <= '0;
          end
        end
        S_DATA:  rgb_q <= bus.fb_rddata;
        S_CLK:   col <= col_last ? '0 : col + 1'b1;
        S_LATCH: begin
          row_q  <= row;
          bright <= ctrl[7:4];
          on_cnt <= '0;
        end
        S_SHOW: begin
          on_cnt <= on_cnt + 1'b1;
          if (show_last) begin
            on_cnt <= '0;
            row    <= row + 1'b1;
            if (row_last) active_buf <= ctrl[0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
